inv_mix_col_iter: RTL and testbench

- Iterative AES InvMixColumns unit for the decryption datapath. It is the inverse of the existing forward mix-column logic.
- Accepts a 128-bit state over a valid/ready handshake and transforms it in place, COLS_PER_CYCLE columns per clock.
- Presents the result on a held valid/ready output port.
- Sits between inverse shift-rows and add-round-key in the iterative decrypt round.

---
 rtl/aes_pkg.sv | 51 +++++
 rtl/inv_mix_single_col.sv | 24 ++
 rtl/inv_mix_col_iter.sv | 94 +++++++++
 tb/tb_inv_mix_col_iter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: field constants, GF(2^8) multipliers built from xtime,
// and the state encoding used by the iterative round units.
package aes_pkg;

    localparam logic [7:0] AES_POLY    = 8'h1b;
    localparam int         AES_STATE_W = 128;
    localparam int         AES_COL_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] x);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(x)));
        return x8 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] x);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = xtime(x);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] x);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = xtime(xtime(x));
        x8 = xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] x);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_single_col.sv
// Combinational InvMixColumns for one 32-bit column; byte b0 sits in the top byte.
module inv_mix_single_col
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] col_i,
    output logic [AES_COL_W-1:0] col_o
);

    logic [7:0] b0, b1, b2, b3;
    logic [7:0] c0, c1, c2, c3;

    assign b0 = col_i[31:24];
    assign b1 = col_i[23:16];
    assign b2 = col_i[15:8];
    assign b3 = col_i[7:0];

    assign c0 = gf_mul14(b0) ^ gf_mul11(b1) ^ gf_mul13(b2) ^ gf_mul9(b3);
    assign c1 = gf_mul9(b0)  ^ gf_mul14(b1) ^ gf_mul11(b2) ^ gf_mul13(b3);
    assign c2 = gf_mul13(b0) ^ gf_mul9(b1)  ^ gf_mul14(b2) ^ gf_mul11(b3);
    assign c3 = gf_mul11(b0) ^ gf_mul13(b1) ^ gf_mul9(b2)  ^ gf_mul14(b3);

    assign col_o = {c0, c1, c2, c3};

endmodule

// File: rtl/inv_mix_col_iter.sv
// Iterative InvMixColumns: captures a state, rewrites COLS_PER_CYCLE columns per
// clock in place, then holds the result until the consumer takes it.
module inv_mix_col_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data
);

    localparam int N     = 4 / COLS_PER_CYCLE;
    // With a single group the counter is never advanced and stays at zero.
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("inv_mix_col_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AES_STATE_W-1:0] data_q, data_d;

    logic [AES_COL_W-1:0]   col_in  [COLS_PER_CYCLE];
    logic [AES_COL_W-1:0]   col_out [COLS_PER_CYCLE];

    generate
        for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
            assign col_in[g] = data_q[(int'(cnt_q) * COLS_PER_CYCLE + g) * AES_COL_W +: AES_COL_W];
            inv_mix_single_col u_col (
                .col_i (col_in[g]),
                .col_o (col_out[g])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    data_d[(int'(cnt_q) * COLS_PER_CYCLE + g) * AES_COL_W +: AES_COL_W] = col_out[g];
                end
                if (cnt_q == CNT_W'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Handshake outputs depend on the registered state only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_inv_mix_col_iter.sv
// Directed bench for inv_mix_col_iter with one, two and four columns per clock.
module tb_inv_mix_col_iter;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         out_ready;

    logic         in_ready1, out_valid1;
    logic [127:0] out_data1;
    logic         in_ready2, out_valid2;
    logic [127:0] out_data2;
    logic         in_ready4, out_valid4;
    logic [127:0] out_data4;

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V2 = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;
    localparam logic [127:0] E2 = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;
    localparam logic [127:0] V3 = 128'hffffffff_00000000_12121212_abababab;

    inv_mix_col_iter #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1)
    );
    inv_mix_col_iter #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2)
    );
    inv_mix_col_iter #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Forward MixColumns reference, used to close the round trip.
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] fwd_mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[c*32+24 +: 8];
            a1 = s[c*32+16 +: 8];
            a2 = s[c*32+8  +: 8];
            a3 = s[c*32    +: 8];
            r[c*32+24 +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            r[c*32+16 +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            r[c*32+8  +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            r[c*32    +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return r;
    endfunction

    // driver: one state through dut1 with latency and handshake checks
    task automatic run_vec(input logic [127:0] data, input logic [127:0] exp,
                           input bit check_exp, output logic [127:0] got);
        int lat;
        chk("pre_in_ready", 128'(in_ready1), 128'(1));
        in_valid = 1'b1;
        in_data  = data;
        tick();
        in_valid = 1'b0;
        chk("busy_in_ready", 128'(in_ready1), 128'(0));
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency1", 128'(lat), 128'(4));
        got = out_data1;
        if (check_exp) chk("data1", got, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_in_ready", 128'(in_ready1), 128'(1));
        chk("idle_out_valid", 128'(out_valid1), 128'(0));
    endtask

    // scoreboard for the streaming run
    logic [127:0] exp_q[$];

    initial begin
        logic [127:0] got, hold, s;
        int lat1, lat2, lat4, n, cyc, last_acc;
        bit acc;
        logic [127:0] sv [3];

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", 128'(out_valid1), 128'(0));
        chk("rst_in_ready", 128'(in_ready1), 128'(1));
        chk("rst_out_data", out_data1, 128'(0));

        // same vector through all three widths, recording when each finishes
        in_valid = 1'b1;
        in_data  = V1;
        tick();
        in_valid = 1'b0;
        lat1 = -1; lat2 = -1; lat4 = -1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (out_valid1 && lat1 < 0) lat1 = c;
            if (out_valid2 && lat2 < 0) lat2 = c;
            if (out_valid4 && lat4 < 0) lat4 = c;
        end
        chk("lat_c1", 128'(lat1), 128'(4));
        chk("lat_c2", 128'(lat2), 128'(2));
        chk("lat_c4", 128'(lat4), 128'(1));
        chk("data_c1", out_data1, E1);
        chk("data_c2", out_data2, E1);
        chk("data_c4", out_data4, E1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_c2", 128'(in_ready2), 128'(1));
        chk("release_c4", 128'(in_ready4), 128'(1));

        run_vec(V2, E2, 1'b1, got);
        chk("rt_directed", fwd_mix(got), V2);
        run_vec(V3, V3, 1'b1, got);

        // round trip through the forward transform
        for (int i = 0; i < 1000; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            run_vec(s, '0, 1'b0, got);
            chk("rt_random", fwd_mix(got), s);
        end

        // backpressure with a stray input pulse while holding a result
        in_valid = 1'b1;
        in_data  = V2;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 20 && !out_valid1; c++) tick();
        hold = out_data1;
        chk("bp_first", hold, E2);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 4);
            in_data  = (i == 4) ? V1 : V2;
            tick();
            chk("bp_out_valid", 128'(out_valid1), 128'(1));
            chk("bp_out_data", out_data1, hold);
            chk("bp_in_ready", 128'(in_ready1), 128'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle_ready", 128'(in_ready1), 128'(1));
        chk("bp_idle_valid", 128'(out_valid1), 128'(0));
        tick();
        chk("bp_no_accept", 128'(in_ready1), 128'(1));

        // reset during the second busy cycle
        in_valid = 1'b1;
        in_data  = V1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_out_valid", 128'(out_valid1), 128'(0));
        chk("mid_rst_in_ready", 128'(in_ready1), 128'(1));
        chk("mid_rst_out_data", out_data1, 128'(0));
        run_vec(V2, E2, 1'b1, got);

        // streaming with in_valid held and out_ready tied high
        sv[0] = V1; sv[1] = V2; sv[2] = V3;
        exp_q.push_back(E1);
        exp_q.push_back(E2);
        exp_q.push_back(V3);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = sv[0];
        n = 0; cyc = 0; last_acc = -1;
        while (cyc < 60 && (n < 3 || exp_q.size() > 0)) begin
            acc = in_valid && in_ready1;
            if (out_valid1) begin
                if (exp_q.size() > 0) chk("stream_data", out_data1, exp_q.pop_front());
                else chk("stream_extra", 128'(1), 128'(0));
            end
            tick();
            cyc++;
            if (acc) begin
                if (last_acc >= 0) chk("stream_spacing", 128'(cyc - last_acc), 128'(6));
                last_acc = cyc;
                n++;
                if (n < 3) in_data = sv[n];
                else in_valid = 1'b0;
            end
        end
        chk("stream_accepts", 128'(n), 128'(3));
        chk("stream_drained", 128'(exp_q.size()), 128'(0));
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
